// File: rtl/traffic_pkg.sv
// Shared definitions for the vehicle signal and pedestrian crossing blocks.
// Light codes from traffic_signal and the pedestrian FSM state encoding.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED   = 2'b00;
  localparam logic [1:0] LIGHT_GREEN = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    CLEAR = 2'b10
  } ped_state_t;

  // Any code other than RED or GREEN is treated as YELLOW.
  function automatic logic is_red(input logic [1:0] code);
    return (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button, followed by a
// single-cycle rising-edge pulse. A held button yields exactly one pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests and grants a
// WALK / flashing clearance phase at the start of a vehicle RED phase.
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = 6,
  parameter int FLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash_dw,
  output logic [3:0] countdown,
  output logic       req_pending
);

  localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES - 1);

  ped_state_t state_r;
  ped_state_t state_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_s;
  logic [1:0] light_q_r;
  logic       req_r;
  logic       req_s;
  logic       btn_rise_s;
  logic       red_entry_s;
  logic       light_red_s;
  logic       enter_walk_s;
  logic       abort_walk_s;
  logic       walk_r;
  logic       walk_s;
  logic       dont_walk_r;
  logic       dont_walk_s;
  logic       flash_r;
  logic       flash_s;
  logic [3:0] countdown_r;
  logic [3:0] countdown_s;

  btn_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (ped_btn),
    .rise (btn_rise_s)
  );

  assign light_red_s = is_red(light);
  // Reset loads light_q_r with RED, so RED present at release is not an entry.
  assign red_entry_s = light_red_s && !is_red(light_q_r);

  // Next state, phase counter and request bookkeeping.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    enter_walk_s = 1'b0;
    abort_walk_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (red_entry_s && (req_r || btn_rise_s)) begin
          state_s      = WALK;
          cnt_s        = WALK_LOAD;
          enter_walk_s = 1'b1;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      WALK: begin
        if (!light_red_s) begin
          state_s      = IDLE;
          cnt_s        = 4'd0;
          abort_walk_s = 1'b1;
        end else if (cnt_r == 4'd0) begin
          state_s = CLEAR;
          cnt_s   = FLASH_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      CLEAR: begin
        if (!light_red_s || (cnt_r == 4'd0)) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    // Entering WALK consumes the request; a new press during WALK/CLEAR
    // or an aborted WALK leaves one pending for the next red.
    if (enter_walk_s) begin
      req_s = 1'b0;
    end else if (btn_rise_s || abort_walk_s) begin
      req_s = 1'b1;
    end else begin
      req_s = req_r;
    end
  end

  // Output decode from the next state so every head is driven by a flop.
  always_comb begin
    walk_s      = (state_s == WALK);
    dont_walk_s = (state_s == IDLE);
    if (state_s == CLEAR) begin
      if (state_r == CLEAR) begin
        flash_s = ~flash_r;
      end else begin
        flash_s = 1'b1;
      end
      countdown_s = cnt_s + 4'd1;
    end else begin
      flash_s     = 1'b0;
      countdown_s = 4'd0;
    end
  end

  // State, counter, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      light_q_r   <= LIGHT_RED;
      req_r       <= 1'b0;
      walk_r      <= 1'b0;
      dont_walk_r <= 1'b1;
      flash_r     <= 1'b0;
      countdown_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      light_q_r   <= light;
      req_r       <= req_s;
      walk_r      <= walk_s;
      dont_walk_r <= dont_walk_s;
      flash_r     <= flash_s;
      countdown_r <= countdown_s;
    end
  end

  assign walk        = walk_r;
  assign dont_walk   = dont_walk_r;
  assign flash_dw    = flash_r;
  assign countdown   = countdown_r;
  assign req_pending = req_r;

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller sitting directly downstream of `traffic_signal`. It consumes the vehicle light code, latches pedestrian push-button requests, and drives the pedestrian WALK / flashing DON'T WALK / DON'T WALK heads plus a clearance countdown. A WALK phase is granted only at the start of a vehicle RED phase, and only if a request is pending.

## Interface

Parameters:
- `WALK_CYCLES`, 6: clock cycles WALK is held (1..15).
- `FLASH_CYCLES`, 4: clock cycles of flashing DON'T WALK clearance (1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `light`  in  2  vehicle light code from `traffic_signal`: 00 RED, 01 GREEN, 10/11 YELLOW.
- `ped_btn`  in  1  raw push button, asynchronous, level.
- `walk`  out  1  WALK head on.
- `dont_walk`  out  1  steady DON'T WALK head on.
- `flash_dw`  out  1  DON'T WALK head during clearance; toggles every cycle.
- `countdown`  out  4  clearance seconds-to-go display; 0 outside CLEAR.
- `req_pending`  out  1  a pedestrian request is latched and not yet served.

## Operation

- Button path: 2-flop synchronizer, then rising-edge detect (`btn_rise`). Holding the button down yields one request.
- `light_q` registers `light` each cycle. `red_entry = (light == 00) && (light_q != 00)`. Red already present at reset release is not an entry.
- `req_pending` is set by `btn_rise` and cleared when WALK is entered. Set and clear in the same cycle: set wins only if the FSM is already in WALK or CLEAR, i.e. a new request for the next red.
- FSM states:
  - IDLE: `dont_walk`=1. On `red_entry && (req_pending || btn_rise)` go to WALK and load `cnt`=WALK_CYCLES-1.
  - WALK: `walk`=1. `cnt` decrements; at `cnt`==0 go to CLEAR and load `cnt`=FLASH_CYCLES-1.
  - CLEAR: `flash_dw` toggles, starting at 1 on entry; `countdown`=`cnt`+1. At `cnt`==0 go to IDLE.
- Abort: if `light` is sampled != 00 while in WALK or CLEAR, go to IDLE on that edge.
  - Abort in WALK re-sets `req_pending`, so the request is served on the next red.
  - Abort in CLEAR counts as served.
- Exactly one of `walk` / `dont_walk` / CLEAR-state is active at any time. `flash_dw` is 0 outside CLEAR.
- `countdown` width rule: `cnt` is 4 bits; `countdown` = `cnt`+1 in CLEAR, which never exceeds 15 given the parameter range.

## Timing

- Reset values: state IDLE, `dont_walk`=1, `walk`=0, `flash_dw`=0, `countdown`=0, `req_pending`=0, `light_q`=00, synchronizer flops 0.
- Mid-operation reset returns to IDLE immediately (asynchronous) and drops any pending request.
- Button latency: if `ped_btn` is first sampled high at edge n, then `btn_rise` is high during cycle n+1→n+2 and `req_pending`=1 after edge n+2.
- WALK latency: `walk` goes high after the first edge that samples `light`=00 following a non-RED sample.
- Phase lengths: `walk` high exactly WALK_CYCLES cycles, then CLEAR exactly FLASH_CYCLES cycles, then `dont_walk` returns.
- All outputs are registered or decoded from registered state; there is no combinational path from `light` or `ped_btn` to any output.

## Structure

- Shared package `traffic_pkg`:
  - light codes `LIGHT_RED`=2'b00 and `LIGHT_GREEN`=2'b01 (anything else is YELLOW), also to be used by `traffic_signal` and its bench;
  - pedestrian FSM state enum `ped_state_t` {IDLE, WALK, CLEAR}.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse, with async active-high reset. Reusable for other push-button inputs.

## Test plan

Use WALK_CYCLES=6 and FLASH_CYCLES=4 throughout.

- Reset: assert `rst` mid-WALK. Required: `walk`=0, `dont_walk`=1, `countdown`=0 and `req_pending`=0 with no clock edge; IDLE after release.
- No request: `light` cycles 01→10→00 with `ped_btn`=0. Required: `dont_walk` stays 1 throughout; `walk` never asserts.
- Normal service: press `ped_btn` during GREEN (`req_pending`=1 after 3 edges), then `light`→00 and hold RED for 15 cycles. Required:
  - `walk`=1 for 6 cycles starting the edge RED is sampled, and `req_pending` drops at that edge;
  - then `countdown` reads 4,3,2,1 with `flash_dw` reading 1,0,1,0;
  - then `dont_walk`=1.
- Mid-red request: press `ped_btn` 3 cycles after RED was entered. Required: no WALK in this red; `req_pending` stays 1 and is served at the next RED entry.
- Early abort: `light`→01 on the 3rd WALK cycle. Required: `dont_walk`=1 next edge, `req_pending`=1 again, WALK restarts at the next RED entry. Repeat with the abort in CLEAR. Required: `req_pending`=0.
- Held button / red at reset: release reset with `light`=00 and `ped_btn` held high for 20 cycles. Required: exactly one request is latched, and no WALK occurs until `light` leaves 00 and re-enters it.
